seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the team's fixed 3-bit-operand ALU.
- Accepts WIDTH-bit unsigned operands with a 2-bit opcode: add, sub, mul, div.
- Add and sub complete in one cycle. Mul (shift-add) and div (restoring) are iterative over WIDTH cycles.
- Returns a double-width result plus status flags over a valid/ready output channel. Sits between the pin-mux/operand registers and the output driver of the top-level wrapper.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state, counters and outputs.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- a  in  WIDTH  operand A (dividend).
- b  in  WIDTH  operand B (divisor).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  see arithmetic rules below.
- flag_zero  out  1  result-is-zero flag.
- flag_carry  out  1  carry (ADD) or borrow (SUB); 0 for MUL/DIV.
- flag_dbz  out  1  divide-by-zero; 0 for other ops.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; result, all flags, counter and operand registers=0; in_ready=1; out_valid=0. Takes effect mid-operation with no partial output.
- Accept: on a rising edge with ena && in_valid && in_ready. a, b and op are captured at that edge; later input changes have no effect.
- States:
  - IDLE -> DONE on accept of ADD/SUB, or of DIV with b==0.
  - IDLE -> BUSY on accept of MUL, or of DIV with b!=0. Counter is set to 0.
  - BUSY: one iteration per enabled edge. On the edge where counter==WIDTH-1, go to DONE.
  - DONE -> IDLE on an edge with ena && out_ready.
- Latency:
  - ADD/SUB/DIV-by-zero: out_valid is high from the edge after the accept edge.
  - MUL/DIV: out_valid is high exactly WIDTH enabled cycles after the accept edge.
- Throughput: no overlap. Next accept is no earlier than the edge after out_ready is taken.
- ena low: no state, counter, register or output changes. Handshakes are ignored, including an in_valid/out_ready that is high during that cycle.
- Arithmetic (all unsigned):
  - ADD: result = {WIDTH-1 zeros, carry, a+b mod 2^WIDTH}; flag_carry = carry.
  - SUB: result = {WIDTH zeros, a-b mod 2^WIDTH}; flag_carry = (a<b).
  - MUL: result = full 2*WIDTH product.
  - DIV: result = {remainder, quotient}.
  - DIV b==0: quotient = all ones, remainder = a, flag_dbz=1.
- flag_zero:
  - MUL: whole result == 0.
  - ADD/SUB/DIV: low WIDTH bits == 0.
- Output hold: result and flags are registered and stable from entry to DONE until the next accept. Their values in IDLE are the previous result; out_valid qualifies them.
- Simultaneous events: in DONE, in_valid is ignored (in_ready=0) while out_ready completes the transfer.

Decomposition:
- Package alu_pkg:
  - op encoding constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, matching the legacy opcode bit mapping.
  - state enum IDLE/BUSY/DONE.
- One sub-module seq_muldiv_core:
  - holds the shared accumulator/shift register and counter.
  - performs one mul or div iteration per enabled cycle.
  - raises a done pulse.
- seq_alu holds the FSM, the handshake, the single-cycle add/sub path and the flag logic.

Test Plan (WIDTH=8):
- ADD a=200 b=100 -> out_valid the cycle after accept; result=0x012C, flag_carry=1, flag_zero=0.
- SUB a=3 b=5 -> result=0x00FE, flag_carry=1. SUB a=7 b=7 -> result=0, flag_zero=1.
- MUL a=255 b=255 -> out_valid exactly 8 cycles after accept; result=0xFE01. Toggling a/b during BUSY does not change the result.
- DIV a=200 b=7 -> result=0x041C (rem 4, quot 28) after 8 cycles. DIV a=0x55 b=0 -> result=0x55FF, flag_dbz=1, one-cycle latency.
- Backpressure and enable:
  - hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0.
  - drop ena for 3 cycles mid-MUL -> total latency becomes 11 cycles, same product.
- Drive rst_n low mid-DIV -> immediately out_valid=0, result=0, in_ready=1. Release and ADD 1+1 -> result=0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: legacy opcode mapping and FSM states.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider sharing one hi:lo register pair.
// After WIDTH iterations {hi, lo} holds the product, or {remainder, quotient}.
module seq_muldiv_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               is_div,
    input  logic               run,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done_c,
    output logic [2*WIDTH-1:0] res_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;

    logic [WIDTH-1:0] hi_nxt, lo_nxt, addend;
    logic [WIDTH:0]   msum, shifted;
    logic             ge;

    // One iteration; res_c exposes the post-iteration value so the final edge can latch it.
    always_comb begin
        addend  = lo_q[0] ? opnd_q : '0;
        msum    = {1'b0, hi_q} + {1'b0, addend};
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd_q});
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (div_q) begin
            hi_nxt = ge ? WIDTH'(shifted - {1'b0, opnd_q}) : shifted[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_nxt = msum[WIDTH:1];
            lo_nxt = {msum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done_c = run && (cnt_q == CNT_W'(WIDTH - 1));
    assign res_c  = {hi_nxt, lo_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else if (ena) begin
            if (start) begin
                hi_q   <= '0;
                lo_q   <= a;
                opnd_q <= b;
                cnt_q  <= '0;
                div_q  <= is_div;
            end else if (run) begin
                hi_q  <= hi_nxt;
                lo_q  <= lo_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked unsigned ALU: single-cycle add/sub, iterative mul/div via seq_muldiv_core.
// result and flags hold their last value until the next accepted operation.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_dbz
);

    localparam int unsigned RW = 2 * WIDTH;

    state_t state_q, state_nxt;
    logic   [1:0] op_q;
    logic   accept, goes_busy, start_core, load_fast, load_core, core_done;
    logic   [RW-1:0] core_res, fast_res;
    logic   [WIDTH:0] sum, diff;
    logic   fast_carry, fast_dbz, fast_zero, core_zero;

    assign accept    = ena && in_valid && (state_q == IDLE);
    assign goes_busy = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (ena) begin
            state_q   <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept) state_nxt = goes_busy ? BUSY : DONE;
            BUSY:    if (ena && core_done) state_nxt = DONE;
            DONE:    if (ena && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_core = accept && goes_busy;
        load_fast  = accept && !goes_busy;
        load_core  = ena && (state_q == BUSY) && core_done;
    end

    // Fast path: add, sub and divide-by-zero resolve at the accept edge.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        fast_res   = '0;
        fast_carry = 1'b0;
        fast_dbz   = 1'b0;
        case (op)
            OP_ADD: begin
                fast_res   = RW'(sum);
                fast_carry = sum[WIDTH];
            end
            OP_SUB: begin
                fast_res   = RW'(diff[WIDTH-1:0]);
                fast_carry = diff[WIDTH];
            end
            OP_DIV: begin
                fast_res = {a, {WIDTH{1'b1}}};
                fast_dbz = 1'b1;
            end
            default: ;
        endcase
        fast_zero = (fast_res[WIDTH-1:0] == '0);
        core_zero = (op_q == OP_MUL) ? (core_res == '0) : (core_res[WIDTH-1:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ADD;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_dbz   <= 1'b0;
        end else if (ena) begin
            if (accept) op_q <= op;
            if (load_fast) begin
                result     <= fast_res;
                flag_zero  <= fast_zero;
                flag_carry <= fast_carry;
                flag_dbz   <= fast_dbz;
            end else if (load_core) begin
                result     <= core_res;
                flag_zero  <= core_zero;
                flag_carry <= 1'b0;
                flag_dbz   <= 1'b0;
            end
        end
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start_core),
        .is_div (op == OP_DIV),
        .run    (state_q == BUSY),
        .a      (a),
        .b      (b),
        .done_c (core_done),
        .res_c  (core_res)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n, ena, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] result;
    logic           flag_zero, flag_carry, flag_dbz;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_dbz   (flag_dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    task automatic model(input logic [1:0] o, input int x, input int y,
                         output int r, output bit c, output bit z, output bit d);
        c = 0; d = 0;
        case (o)
            OP_ADD: begin r = x + y; c = (x + y) > 255; z = ((x + y) % 256) == 0; end
            OP_SUB: begin r = (x - y + 256) % 256; c = x < y; z = r == 0; end
            OP_MUL: begin r = x * y; z = r == 0; end
            default: begin
                if (y == 0) begin r = x * 256 + 255; d = 1; z = 0; end
                else begin r = (x % y) * 256 + x / y; z = (x / y) == 0; end
            end
        endcase
    endtask

    // One transaction; lat = clock edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input int gap, input bit toggle);
        int  r, n, exp_lat;
        bit  c, z, d;
        model(o, int'(x), int'(y), r, c, z, d);
        exp_lat = ((o == OP_MUL) || (o == OP_DIV && y != 0)) ? int'(W) + ((gap > 0) ? 3 : 0) : 0;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (toggle) begin a = W'($urandom); b = W'($urandom); op = 2'($urandom); end
            @(negedge clk);
            n++;
            if (gap > 0 && n == gap) ena = 1'b0;
            if (gap > 0 && n == gap + 3) ena = 1'b1;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("out_valid", 32'(out_valid), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("result", 32'(result), 32'(r));
        check("flag_carry", 32'(flag_carry), 32'(c));
        check("flag_zero", 32'(flag_zero), 32'(z));
        check("flag_dbz", 32'(flag_dbz), 32'(d));
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin ena = 1'b0; out_ready = 1'b1; in_valid = 1'b1; end
            @(negedge clk);
            ena = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'(r));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        check("idle_result", 32'(result), 32'(r));
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_ADD; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({flag_zero, flag_carry, flag_dbz}), 32'd0);

        // Request while disabled must not be accepted.
        ena = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 8'd9; b = 8'd9;
        repeat (2) @(negedge clk);
        check("ena_low_no_accept", 32'(out_valid), 32'd0);
        check("ena_low_ready", 32'(in_ready), 32'd1);
        ena = 1'b1; in_valid = 1'b0;

        run_op(OP_ADD, 8'd200, 8'd100, 5, 0, 1'b0);
        run_op(OP_SUB, 8'd3, 8'd5, 0, 0, 1'b0);
        run_op(OP_SUB, 8'd7, 8'd7, 0, 0, 1'b0);
        run_op(OP_MUL, 8'd255, 8'd255, 0, 0, 1'b1);
        run_op(OP_DIV, 8'd200, 8'd7, 0, 0, 1'b1);
        run_op(OP_DIV, 8'h55, 8'd0, 0, 0, 1'b0);
        run_op(OP_MUL, 8'd255, 8'd255, 0, 2, 1'b0);
        run_op(OP_MUL, 8'd0, 8'd77, 0, 0, 1'b0);
        run_op(OP_DIV, 8'd5, 8'd9, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIV; a = 8'd200; b = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_ADD, 8'd1, 8'd1, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] rx, ry;
            ro = 2'($urandom_range(0, 3));
            rx = W'($urandom);
            ry = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_op(ro, rx, ry, int'($urandom_range(0, 2)), 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
